// File: rtl/can_fifo_pkg.sv
// Shared constants for the CAN message FIFO: default geometry and read-mode encodings.
package can_fifo_pkg;
   localparam int CAN_FIFO_DATA_W = 128;
   localparam int CAN_FIFO_ADDR_W = 3;
   localparam int FIFO_MODE_STD   = 0;
   localparam int FIFO_MODE_FWFT  = 1;
endpackage

// File: rtl/can_fifo_ram.sv
// Simple dual-port message store: synchronous write, asynchronous read.
module can_fifo_ram #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/can_msg_fifo.sv
// CAN Tx/Rx message FIFO: wrap-bit pointers, occupancy flags, sticky errors, flush,
// and a choice of registered or first-word-fall-through read path.
module can_msg_fifo
   import can_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = CAN_FIFO_DATA_W,
   parameter int ADDR_WIDTH    = CAN_FIFO_ADDR_W,
   parameter int AFULL_THRESH  = 6,
   parameter int AEMPTY_THRESH = 1,
   parameter int FWFT          = FIFO_MODE_STD
) (
   input  logic                  i_sys_clk,
   input  logic                  i_reset_n,
   input  logic                  i_flush,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_fifo_w_data,
   input  logic                  i_r_en,
   input  logic                  i_clr_err,
   output logic [DATA_WIDTH-1:0] o_fifo_r_data,
   output logic                  o_r_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8 ||
       AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
       AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH-1 ||
       (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_bad_param
      $error("can_msg_fifo: illegal parameter combination");
   end

   logic [ADDR_WIDTH:0]   wptr, rptr, count;
   logic                  empty, full, rd_acc, wr_acc, ovf_set, udf_set;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                  (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

   // Flush wins over both requests and must not be mistaken for a rejected access.
   assign rd_acc  = i_r_en & ~empty & ~i_flush;
   assign wr_acc  = i_wr_en & (~full | rd_acc) & ~i_flush;
   assign ovf_set = i_wr_en & ~wr_acc & ~i_flush;
   assign udf_set = i_r_en & ~rd_acc & ~i_flush;

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wptr        <= '0;
         rptr        <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (i_flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
         end
         o_overflow  <= ovf_set | (o_overflow  & ~i_clr_err);
         o_underflow <= udf_set | (o_underflow & ~i_clr_err);
      end
   end

   can_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (i_sys_clk),
      .we    (wr_acc),
      .waddr (wptr[ADDR_WIDTH-1:0]),
      .wdata (i_fifo_w_data),
      .raddr (rptr[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   assign o_count        = count;
   assign o_empty        = empty;
   assign o_full         = full;
   assign o_almost_full  = (count >= AF_TH);
   assign o_almost_empty = (count <= AE_TH);

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Mask the head so an empty FIFO never exposes stale or unwritten RAM.
      assign o_fifo_r_data = empty ? '0 : ram_rdata;
      assign o_r_valid     = ~empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_valid;
      always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
         if (!i_reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= rd_acc;
            if (rd_acc) r_data <= ram_rdata;
         end
      end
      assign o_fifo_r_data = r_data;
      assign o_r_valid     = r_valid;
   end
endmodule

// File: tb/tb_can_msg_fifo.sv
// Randomized + directed bench for can_msg_fifo: instance 0 standard read, instance 1 FWFT,
// each checked every cycle against a queue-based model and a read-data scoreboard.
module tb_can_msg_fifo;
   localparam int DW = 128;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   localparam int AF = 6;
   localparam int AE = 1;

   logic gclk = 1'b0;
   logic grst_n = 1'b0;
   always #5 gclk = ~gclk;

   logic [1:0]    flush, wr, rd, clr;
   logic [DW-1:0] wd [2];
   logic [DW-1:0] rdata [2];
   logic [1:0]    rv, full, empty, af, ae, ovf, udf;
   logic [AW:0]   cnt [2];

   int n_chk = 0;
   int n_pass = 0;

   can_msg_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(0)) dut_std (
      .i_sys_clk(gclk), .i_reset_n(grst_n), .i_flush(flush[0]), .i_wr_en(wr[0]),
      .i_fifo_w_data(wd[0]), .i_r_en(rd[0]), .i_clr_err(clr[0]),
      .o_fifo_r_data(rdata[0]), .o_r_valid(rv[0]), .o_full(full[0]), .o_empty(empty[0]),
      .o_almost_full(af[0]), .o_almost_empty(ae[0]), .o_count(cnt[0]),
      .o_overflow(ovf[0]), .o_underflow(udf[0]));

   can_msg_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(1)) dut_fwft (
      .i_sys_clk(gclk), .i_reset_n(grst_n), .i_flush(flush[1]), .i_wr_en(wr[1]),
      .i_fifo_w_data(wd[1]), .i_r_en(rd[1]), .i_clr_err(clr[1]),
      .o_fifo_r_data(rdata[1]), .o_r_valid(rv[1]), .o_full(full[1]), .o_empty(empty[1]),
      .o_almost_full(af[1]), .o_almost_empty(ae[1]), .o_count(cnt[1]),
      .o_overflow(ovf[1]), .o_underflow(udf[1]));

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_model
      logic [DW-1:0] q [$];
      logic [DW-1:0] sb [$];
      logic [DW-1:0] m_rd;
      bit m_ovf, m_udf, m_rv;

      // Reference behaviour: plain queue semantics with the accept and error rules.
      always @(posedge gclk or negedge grst_n) begin
         if (!grst_n) begin
            q.delete(); sb.delete();
            m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
         end else begin
            int n;
            bit rda, wra, oset, uset;
            logic [DW-1:0] v;
            n = q.size();
            rda = rd[k] && n > 0 && !flush[k];
            wra = wr[k] && (n < DEPTH || rda) && !flush[k];
            oset = wr[k] && !wra && !flush[k];
            uset = rd[k] && !rda && !flush[k];
            m_rv = 0;
            if (flush[k]) q.delete();
            else begin
               if (rda) begin
                  v = q.pop_front();
                  if (k == 0) begin sb.push_back(v); m_rd = v; m_rv = 1; end
               end
               if (wra) q.push_back(wd[k]);
            end
            m_ovf = oset ? 1'b1 : (clr[k] ? 1'b0 : m_ovf);
            m_udf = uset ? 1'b1 : (clr[k] ? 1'b0 : m_udf);
         end
      end

      always @(negedge gclk) begin
         if (grst_n) begin
            int n;
            n = q.size();
            chk($sformatf("count%0d", k), DW'(cnt[k]), DW'(n));
            chk($sformatf("full%0d", k), DW'(full[k]), DW'(n == DEPTH));
            chk($sformatf("empty%0d", k), DW'(empty[k]), DW'(n == 0));
            chk($sformatf("afull%0d", k), DW'(af[k]), DW'(n >= AF));
            chk($sformatf("aempty%0d", k), DW'(ae[k]), DW'(n <= AE));
            chk($sformatf("overflow%0d", k), DW'(ovf[k]), DW'(m_ovf));
            chk($sformatf("underflow%0d", k), DW'(udf[k]), DW'(m_udf));
            if (k == 0) begin
               chk("std_r_valid", DW'(rv[0]), DW'(m_rv));
               chk("std_r_data_hold", rdata[0], m_rd);
               if (rv[0]) begin
                  if (sb.size() == 0) chk("std_sb_underrun", DW'(1), DW'(0));
                  else chk("std_read_word", rdata[0], sb.pop_front());
               end
            end else begin
               chk("fwft_r_valid", DW'(rv[1]), DW'(n > 0));
               if (n > 0) chk("fwft_head", rdata[1], q[0]);
            end
         end
      end
   end

   task automatic drive(input int k, input bit w, input logic [DW-1:0] d,
                        input bit r, input bit f, input bit c);
      @(negedge gclk);
      flush = '0; wr = '0; rd = '0; clr = '0;
      flush[k] = f; wr[k] = w; rd[k] = r; clr[k] = c; wd[k] = d;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      flush = '0; wr = '0; rd = '0; clr = '0; wd[0] = '0; wd[1] = '0;
      repeat (2) @(negedge gclk);
      #1;
      chk("rst_count", DW'(cnt[0]), DW'(0));
      chk("rst_empty", DW'(empty[0]), DW'(1));
      chk("rst_aempty", DW'(ae[0]), DW'(1));
      chk("rst_rdata", rdata[0], DW'(0));
      chk("rst_rvalid_fwft", DW'(rv[1]), DW'(0));
      grst_n = 1'b1;

      // Fill, overflow, clear, full write+read, drain
      for (int i = 1; i <= 8; i++) drive(0, 1, DW'(i), 0, 0, 0);
      drive(0, 1, DW'('h9), 0, 0, 0);
      drive(0, 0, '0, 0, 0, 1);
      drive(0, 1, DW'('hA), 1, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, '0, 1, 0, 0);
      // Underflow, then write+read on empty
      drive(0, 0, '0, 1, 0, 0);
      drive(0, 1, DW'('h5), 1, 0, 0);
      drive(0, 0, '0, 0, 0, 1);
      drive(0, 0, '0, 1, 0, 0);
      // Pointer wrap
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, DW'(i), 0, 0, 0);
         drive(0, 0, '0, 1, 0, 0);
      end
      drive(0, 0, '0, 0, 0, 0);

      // FWFT: fall-through, pop, flush overriding requests
      drive(1, 1, DW'('h3C), 0, 0, 0);
      drive(1, 0, '0, 0, 0, 0);
      drive(1, 0, '0, 1, 0, 0);
      drive(1, 0, '0, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 1, rnd_word(), 0, 0, 0);
      drive(1, 1, rnd_word(), 1, 1, 0);
      drive(1, 0, '0, 0, 0, 0);

      // Random traffic on both instances, with one asynchronous reset mid-run
      for (int i = 0; i < 800; i++) begin
         @(negedge gclk);
         for (int k = 0; k < 2; k++) begin
            wr[k]    = ($urandom_range(99) < 55);
            rd[k]    = ($urandom_range(99) < (i < 400 ? 40 : 60));
            flush[k] = ($urandom_range(99) < 2);
            clr[k]   = ($urandom_range(99) < 8);
            wd[k]    = rnd_word();
         end
         if (i == 500) begin
            #3 grst_n = 1'b0;
            #1;
            chk("async_rst_count0", DW'(cnt[0]), DW'(0));
            chk("async_rst_rvalid0", DW'(rv[0]), DW'(0));
            chk("async_rst_rdata0", rdata[0], DW'(0));
            chk("async_rst_ovf0", DW'(ovf[0]), DW'(0));
            chk("async_rst_empty1", DW'(empty[1]), DW'(1));
            chk("async_rst_udf1", DW'(udf[1]), DW'(0));
            @(negedge gclk);
            grst_n = 1'b1;
         end
      end
      drive(0, 0, '0, 0, 0, 0);
      flush = '0; wr = '0; rd = '0; clr = '0;
      repeat (3) @(negedge gclk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
